// File: rtl/spfp_pkg.sv
// ---------------------------------------------------------------------------
// spfp_pkg
// Shared definitions for the single-precision floating-point divider:
// IEEE-754 field widths, canonical special encodings, result-flag bit
// positions, FSM state encoding and an operand classifier.
//
// Build option: define SPFP_DIV_ROUND_EN to add one extra division
// iteration (guard bit) and round-to-nearest-even on the fraction.
// Without it the quotient is truncated toward zero.
// ---------------------------------------------------------------------------
package spfp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam int FP_W  = 1 + EXP_W + MAN_W;
    // Significand including the hidden leading one.
    localparam int SIG_W = MAN_W + 1;
    // Quotient bits needed for a normalised truncated result: one integer
    // bit (set when fa >= fb) plus the 24 significand bits below it.
    localparam int QUO_W = SIG_W + 1;
`ifdef SPFP_DIV_ROUND_EN
    localparam int ITERS = QUO_W + 1;
`else
    localparam int ITERS = QUO_W;
`endif
    // The partial remainder stays below 2*fb, so one bit above SIG_W suffices.
    localparam int REM_W = SIG_W + 1;
    // Signed working exponent with headroom for ea - eb + BIAS.
    localparam int E_W   = EXP_W + 2;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC00000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F800000;

    localparam int FLG_INV = 3;
    localparam int FLG_DZ  = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] NORM   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Denormals (exponent field zero) are flushed and treated as zero.
    function automatic fp_class_t classify(input logic [FP_W-1:0] x);
        fp_class_t          c;
        logic [EXP_W-1:0]   e;
        logic [MAN_W-1:0]   f;
        e         = x[MAN_W +: EXP_W];
        f         = x[MAN_W-1:0];
        c.is_zero = (e == '0);
        c.is_inf  = (e == '1) && (f == '0);
        c.is_nan  = (e == '1) && (f != '0);
        return c;
    endfunction

endpackage

// File: rtl/spfp_sig_divider.sv
// ---------------------------------------------------------------------------
// spfp_sig_divider
// Restoring significand divider producing one quotient bit per clock,
// most significant bit first. Computes floor(dividend * 2^(ITERS-1) / divisor)
// for 24-bit significands that both carry the hidden one.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load new operands and begin iterating (ignored while busy
//              by construction of the parent FSM)
//   dividend   24-bit significand fa
//   divisor    24-bit significand fb
//   quo        quotient shift register, ITERS bits, valid after done
//   done       high during the clock whose edge performs the last iteration
//   rem_nz     final remainder is non-zero (sticky); SPFP_DIV_ROUND_EN only
// ---------------------------------------------------------------------------
module spfp_sig_divider
    import spfp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] dividend,
    input  logic [SIG_W-1:0] divisor,
    output logic [ITERS-1:0] quo,
`ifdef SPFP_DIV_ROUND_EN
    output logic             rem_nz,
`endif
    output logic             done
);

    localparam int               CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITERS - 1);

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] dvs_ext;
    logic [REM_W-1:0] diff;
    logic [REM_W-1:0] rem_sel;
    logic [SIG_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             ge;

    // Trial subtraction: the quotient bit is 1 when the divisor fits in the
    // current remainder, in which case the difference becomes the remainder.
    always_comb begin
        dvs_ext = {1'b0, dvs};
        ge      = (rem >= dvs_ext);
        diff    = rem - dvs_ext;
        rem_sel = ge ? diff : rem;
    end

    assign done = busy && (cnt == LAST);
`ifdef SPFP_DIV_ROUND_EN
    assign rem_nz = |rem;
`endif

    // Iteration register bank. The remainder is doubled after every step so
    // the next comparison tests the following binary digit of the quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= {1'b0, dividend};
            dvs  <= divisor;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            quo <= {quo[ITERS-2:0], ge};
            rem <= rem_sel << 1;
            if (cnt == LAST) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_fp_divider.sv
// ---------------------------------------------------------------------------
// sp_fp_divider
// Iterative IEEE-754 single-precision divider, quotient = op_a / op_b.
// Multi-cycle (not pipelined) with valid/ready handshakes on both sides.
// Special operands finish one cycle after acceptance; normal operands go
// through the restoring significand divider, then normalise and range-check.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_valid    operand pair present; accepted when i_valid & o_ready
//   o_ready    divider idle
//   op_a       dividend (IEEE-754 single)
//   op_b       divisor  (IEEE-754 single)
//   o_valid    result present; consumed when o_valid & i_ready
//   i_ready    consumer ready
//   quotient   result {sign, exp, frac}, held stable while o_valid
//   o_flags    {invalid, div_by_zero, overflow, underflow}
//
// Build option: SPFP_DIV_ROUND_EN enables round-to-nearest-even (one extra
// iteration, 28-cycle normal latency); otherwise truncation, 27 cycles.
// ---------------------------------------------------------------------------
module sp_fp_divider
    import spfp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [FP_W-1:0] op_a,
    input  logic [FP_W-1:0] op_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [FP_W-1:0] quotient,
    output logic [3:0]      o_flags
);

    localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
    localparam logic signed [E_W-1:0] E_ZERO = '0;
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);

    logic [1:0]              state;
    fp_class_t               cls_a;
    fp_class_t               cls_b;
    logic                    sign_in;
    logic                    accept;
    logic                    is_special;
    logic [FP_W-1:0]         spec_q;
    logic [3:0]              spec_f;
    logic signed [E_W-1:0]   ea_s;
    logic signed [E_W-1:0]   eb_s;
    logic signed [E_W-1:0]   e_in;

    logic                    sign_r;
    logic signed [E_W-1:0]   e_r;

    logic                    sig_start;
    logic                    sig_done;
    logic [ITERS-1:0]        sig_quo;
    logic [SIG_W-1:0]        sig_a;
    logic [SIG_W-1:0]        sig_b;

    logic [QUO_W-1:0]        q_main;
    logic [MAN_W-1:0]        frac_n;
    logic [MAN_W-1:0]        frac_f;
    logic signed [E_W-1:0]   e_n;
    logic signed [E_W-1:0]   e_f;
    logic [FP_W-1:0]         norm_q;
    logic [3:0]              norm_f;
`ifdef SPFP_DIV_ROUND_EN
    logic                    sig_rem_nz;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [MAN_W:0]          frac_sum;
`endif

    assign o_ready   = (state == IDLE);
    assign o_valid   = (state == DONE);
    assign accept    = o_ready && i_valid;
    assign sig_start = accept && !is_special;
    assign sig_a     = {1'b1, op_a[MAN_W-1:0]};
    assign sig_b     = {1'b1, op_b[MAN_W-1:0]};

    // Operand classification and special-case resolution, in priority order
    // from NaN down to zero dividend. Only a pair that falls through every
    // case needs the iterative datapath.
    always_comb begin
        cls_a      = classify(op_a);
        cls_b      = classify(op_b);
        sign_in    = op_a[FP_W-1] ^ op_b[FP_W-1];
        is_special = 1'b1;
        spec_q     = '0;
        spec_f     = '0;
        if (cls_a.is_nan || cls_b.is_nan) begin
            spec_q          = QNAN;
            spec_f[FLG_INV] = 1'b1;
        end else if ((cls_a.is_zero && cls_b.is_zero) || (cls_a.is_inf && cls_b.is_inf)) begin
            spec_q          = QNAN;
            spec_f[FLG_INV] = 1'b1;
        end else if (cls_b.is_zero && !cls_a.is_inf) begin
            spec_q         = {sign_in, POS_INF[FP_W-2:0]};
            spec_f[FLG_DZ] = 1'b1;
        end else if (cls_a.is_inf) begin
            spec_q = {sign_in, POS_INF[FP_W-2:0]};
        end else if (cls_b.is_inf || cls_a.is_zero) begin
            spec_q = {sign_in, {(FP_W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end

        ea_s = {{(E_W-EXP_W){1'b0}}, op_a[MAN_W +: EXP_W]};
        eb_s = {{(E_W-EXP_W){1'b0}}, op_b[MAN_W +: EXP_W]};
        e_in = ea_s - eb_s + E_BIAS;
    end

    spfp_sig_divider u_sig_div (
        .clk      (clk),
        .rst      (rst),
        .start    (sig_start),
        .dividend (sig_a),
        .divisor  (sig_b),
        .quo      (sig_quo),
`ifdef SPFP_DIV_ROUND_EN
        .rem_nz   (sig_rem_nz),
`endif
        .done     (sig_done)
    );

    // Normalisation: when fa >= fb the integer quotient bit is set and the
    // fraction sits one place higher; otherwise the exponent drops by one.
    // With rounding, the bit below the kept fraction is the guard and any
    // lower quotient bit or leftover remainder forms the sticky bit. A carry
    // out of the fraction bumps the exponent before the range check.
    always_comb begin
        q_main = sig_quo[ITERS-1 -: QUO_W];
        if (q_main[QUO_W-1]) begin
            frac_n = q_main[MAN_W:1];
            e_n    = e_r;
        end else begin
            frac_n = q_main[MAN_W-1:0];
            e_n    = e_r - E_ONE;
        end

`ifdef SPFP_DIV_ROUND_EN
        if (q_main[QUO_W-1]) begin
            guard  = q_main[0];
            sticky = sig_quo[0] | sig_rem_nz;
        end else begin
            guard  = sig_quo[0];
            sticky = sig_rem_nz;
        end
        round_up = guard & (sticky | frac_n[0]);
        frac_sum = {1'b0, frac_n} + {{MAN_W{1'b0}}, round_up};
        frac_f   = frac_sum[MAN_W-1:0];
        e_f      = frac_sum[MAN_W] ? (e_n + E_ONE) : e_n;
`else
        frac_f = frac_n;
        e_f    = e_n;
`endif

        norm_f = '0;
        if (e_f >= E_MAX) begin
            norm_q          = {sign_r, POS_INF[FP_W-2:0]};
            norm_f[FLG_OVF] = 1'b1;
        end else if (e_f <= E_ZERO) begin
            norm_q          = {sign_r, {(FP_W-1){1'b0}}};
            norm_f[FLG_UNF] = 1'b1;
        end else begin
            norm_q = {sign_r, e_f[EXP_W-1:0], frac_f};
        end
    end

    // Control FSM. Specials bypass the datapath and land in DONE on the
    // accept edge. DIVIDE leaves on the edge of the final iteration so NORM
    // sees the complete quotient. Result registers only change when a new
    // result is produced, keeping them stable throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            quotient <= '0;
            o_flags  <= '0;
            sign_r   <= 1'b0;
            e_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sign_r <= sign_in;
                        e_r    <= e_in;
                        if (is_special) begin
                            quotient <= spec_q;
                            o_flags  <= spec_f;
                            state    <= DONE;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (sig_done) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    quotient <= norm_q;
                    o_flags  <= norm_f;
                    state    <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
